// File: rtl/hazard_sequencer_if.sv
// Control bundle between the 5-stage datapath and the hazard sequencer.
// The datapath (master) presents hazard status; the sequencer (slave)
// returns the per-stage enable/flush controls and status readouts.
interface hazard_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             ihit;
    logic             dhit;
    logic             mem_dREN;
    logic             mem_dWEN;
    logic             mem_halt;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             ex_dREN;
    logic [4:0]       ex_rt;
    logic             ex_redirect;

    logic             pc_en;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_en;
    logic             idex_flush;
    logic             exmem_en;
    logic             memwb_en;
    logic             halted;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output ihit, dhit, mem_dREN, mem_dWEN, mem_halt,
               id_rs, id_rt, id_uses_rt, ex_dREN, ex_rt, ex_redirect,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
               exmem_en, memwb_en, halted, stall_cnt
    );

    modport slave (
        input  ihit, dhit, mem_dREN, mem_dWEN, mem_halt,
               id_rs, id_rt, id_uses_rt, ex_dREN, ex_rt, ex_redirect,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
               exmem_en, memwb_en, halted, stall_cnt
    );
endinterface

// File: rtl/hazard_sequencer.sv
// Central pipeline controller: per-cycle enable/flush generation for the
// PC and the four pipeline registers, halt drain sequencing, and a
// saturating stall-cycle counter for performance readout.
module hazard_sequencer #(
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic               CLK,
    input  logic               RST,
    hazard_sequencer_if.slave  hz
);

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } state_t;

    localparam logic [2:0] DRAIN_LAST = 3'(DRAIN_CYCLES - 1);

    state_t           state_reg, state_next;
    logic [2:0]       drain_cnt_reg, drain_cnt_next;
    logic [CNT_W-1:0] stall_cnt_reg;

    logic dmem_wait;
    logic load_use;
    logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en;
    logic halted;

    // A pending data access freezes the whole pipe; a load whose result is
    // needed by the instruction in ID (rt only when it is really a source)
    // forces one bubble. Register 0 never carries a real dependency.
    assign dmem_wait = (hz.mem_dREN | hz.mem_dWEN) & ~hz.dhit;
    assign load_use  = hz.ex_dREN && (hz.ex_rt != 5'd0) &&
                       ((hz.ex_rt == hz.id_rs) ||
                        (hz.id_uses_rt && (hz.ex_rt == hz.id_rt)));

    // State, drain counter and stall counter registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg     <= INIT;
            drain_cnt_reg <= 3'd0;
            stall_cnt_reg <= '0;
        end else begin
            state_reg     <= state_next;
            drain_cnt_reg <= drain_cnt_next;
            if (state_reg == RUN && !pc_en && stall_cnt_reg != '1)
                stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end

    // Next-state and control outputs; priority in RUN is
    // dmem wait > redirect > load-use > ifetch miss > normal flow.
    always_comb begin
        state_next     = state_reg;
        drain_cnt_next = drain_cnt_reg;
        pc_en          = 1'b0;
        ifid_en        = 1'b0;
        ifid_flush     = 1'b0;
        idex_en        = 1'b0;
        idex_flush     = 1'b0;
        exmem_en       = 1'b0;
        memwb_en       = 1'b0;
        halted         = 1'b0;

        case (state_reg)
            INIT: begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
                state_next = RUN;
            end

            RUN: begin
                if (dmem_wait) begin
                    // everything frozen; pending redirect/hazard is held
                end else if (hz.ex_redirect) begin
                    pc_en      = 1'b1;
                    ifid_en    = 1'b1;
                    ifid_flush = 1'b1;
                    idex_en    = 1'b1;
                    idex_flush = 1'b1;
                    exmem_en   = 1'b1;
                    memwb_en   = 1'b1;
                end else if (load_use) begin
                    idex_en    = 1'b1;
                    idex_flush = 1'b1;
                    exmem_en   = 1'b1;
                    memwb_en   = 1'b1;
                end else if (!hz.ihit) begin
                    ifid_en    = 1'b1;
                    ifid_flush = 1'b1;
                    idex_en    = 1'b1;
                    exmem_en   = 1'b1;
                    memwb_en   = 1'b1;
                end else begin
                    pc_en      = 1'b1;
                    ifid_en    = 1'b1;
                    idex_en    = 1'b1;
                    exmem_en   = 1'b1;
                    memwb_en   = 1'b1;
                end

                // HALT moves into MEM/WB this cycle unless the pipe is frozen
                if (hz.mem_halt && !dmem_wait) begin
                    state_next     = DRAIN;
                    drain_cnt_next = 3'd0;
                end
            end

            DRAIN: begin
                ifid_en    = 1'b1;
                ifid_flush = 1'b1;
                idex_en    = 1'b1;
                idex_flush = 1'b1;
                memwb_en   = 1'b1;
                if (drain_cnt_reg == DRAIN_LAST) begin
                    state_next     = HALTED;
                    drain_cnt_next = 3'd0;
                end else begin
                    drain_cnt_next = drain_cnt_reg + 3'd1;
                end
            end

            HALTED: begin
                halted = 1'b1;
            end

            default: begin
                state_next = INIT;
            end
        endcase
    end

    assign hz.pc_en      = pc_en;
    assign hz.ifid_en    = ifid_en;
    assign hz.ifid_flush = ifid_flush;
    assign hz.idex_en    = idex_en;
    assign hz.idex_flush = idex_flush;
    assign hz.exmem_en   = exmem_en;
    assign hz.memwb_en   = memwb_en;
    assign hz.halted     = halted;
    assign hz.stall_cnt  = stall_cnt_reg;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench for hazard_sequencer: table-driven vectors plus
// hand-written multi-cycle sequences, checked through an expected-value queue.
module tb_hazard_sequencer;

    localparam int CNT_W = 4;
    localparam int DRAIN_CYCLES = 2;

    // control bits order: {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en}
    localparam logic [6:0] C_INIT   = 7'b0010100;
    localparam logic [6:0] C_NORM   = 7'b1101011;
    localparam logic [6:0] C_FROZEN = 7'b0000000;
    localparam logic [6:0] C_REDIR  = 7'b1111111;
    localparam logic [6:0] C_LDUSE  = 7'b0001111;
    localparam logic [6:0] C_IMISS  = 7'b0111011;
    localparam logic [6:0] C_DRAIN  = 7'b0111101;
    localparam logic [6:0] C_HALT   = 7'b0000000;

    typedef struct {
        logic       ihit, dhit, dren, dwen, halt;
        logic [4:0] rs, rt;
        logic       uses_rt, ex_dren;
        logic [4:0] ex_rt;
        logic       redir;
        logic [6:0] ctrl;
        logic       halted;
        logic       run;
    } vec_t;

    typedef struct {
        logic [6:0]       ctrl;
        logic             halted;
        logic [CNT_W-1:0] sc;
        string            name;
    } exp_t;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   tests = 0;
    int   fails = 0;
    logic [CNT_W-1:0] sc_model = '0;
    exp_t sb[$];

    hazard_sequencer_if #(.CNT_W(CNT_W)) hz ();

    hazard_sequencer #(.DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(CNT_W)) dut (
        .CLK (CLK),
        .RST (RST),
        .hz  (hz.slave)
    );

    always #5 CLK = ~CLK;

    function automatic vec_t mk(input logic ihit, input logic dhit, input logic dren,
                                input logic dwen, input logic halt, input logic [4:0] rs,
                                input logic [4:0] rt, input logic uses_rt, input logic ex_dren,
                                input logic [4:0] ex_rt, input logic redir,
                                input logic [6:0] ctrl, input logic halted, input logic run);
        vec_t v;
        v.ihit = ihit; v.dhit = dhit; v.dren = dren; v.dwen = dwen; v.halt = halt;
        v.rs = rs; v.rt = rt; v.uses_rt = uses_rt; v.ex_dren = ex_dren;
        v.ex_rt = ex_rt; v.redir = redir; v.ctrl = ctrl; v.halted = halted; v.run = run;
        return v;
    endfunction

    // Idle RUN inputs with an expectation attached.
    function automatic vec_t idle(input logic [6:0] ctrl, input logic halted, input logic run);
        return mk(1, 1, 0, 0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, ctrl, halted, run);
    endfunction

    task automatic check_front();
        exp_t e;
        logic [6:0] act;
        if (sb.size() == 0) begin
            tests++; fails++;
            $display("FAIL %s: scoreboard empty", "sb_empty");
            return;
        end
        e = sb.pop_front();
        act = {hz.pc_en, hz.ifid_en, hz.ifid_flush, hz.idex_en, hz.idex_flush,
               hz.exmem_en, hz.memwb_en};
        tests++;
        if (act !== e.ctrl) begin
            fails++;
            $display("FAIL %s ctrl: got %b expected %b", e.name, act, e.ctrl);
        end
        tests++;
        if (hz.halted !== e.halted) begin
            fails++;
            $display("FAIL %s halted: got %b expected %b", e.name, hz.halted, e.halted);
        end
        tests++;
        if (hz.stall_cnt !== e.sc) begin
            fails++;
            $display("FAIL %s stall_cnt: got %0d expected %0d", e.name, hz.stall_cnt, e.sc);
        end
    endtask

    // One cycle: drive inputs, queue expectation, compare at negedge,
    // advance past the clock edge and update the stall counter model.
    task automatic step(input vec_t v, input string name);
        exp_t e;
        hz.ihit = v.ihit; hz.dhit = v.dhit; hz.mem_dREN = v.dren; hz.mem_dWEN = v.dwen;
        hz.mem_halt = v.halt; hz.id_rs = v.rs; hz.id_rt = v.rt; hz.id_uses_rt = v.uses_rt;
        hz.ex_dREN = v.ex_dren; hz.ex_rt = v.ex_rt; hz.ex_redirect = v.redir;
        e.ctrl = v.ctrl; e.halted = v.halted; e.sc = sc_model; e.name = name;
        sb.push_back(e);
        @(negedge CLK);
        check_front();
        $display("[TB] %s ctrl=%b halted=%b stall_cnt=%0d", name,
                 {hz.pc_en, hz.ifid_en, hz.ifid_flush, hz.idex_en, hz.idex_flush,
                  hz.exmem_en, hz.memwb_en}, hz.halted, hz.stall_cnt);
        @(posedge CLK);
        #1;
        if (!RST && v.run && !v.ctrl[6] && sc_model != '1)
            sc_model = sc_model + 1'b1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        sc_model = '0;
        for (int i = 0; i < 3; i++) step(idle(C_INIT, 0, 0), "reset_hold");
        RST = 1'b0;
        step(idle(C_INIT, 0, 0), "init");
    endtask

    vec_t tbl[12];

    initial begin
        hz.ihit = 1; hz.dhit = 1; hz.mem_dREN = 0; hz.mem_dWEN = 0; hz.mem_halt = 0;
        hz.id_rs = 0; hz.id_rt = 0; hz.id_uses_rt = 0; hz.ex_dREN = 0; hz.ex_rt = 0;
        hz.ex_redirect = 0;
        #1;

        //            ihit dhit dren dwen halt rs  rt  urt exd exrt rdr ctrl   hlt run
        tbl[0]  = mk(1, 1, 0, 0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, C_NORM,  0, 1);
        tbl[1]  = mk(1, 1, 0, 0, 0, 5'd5, 5'd0, 0, 1, 5'd5, 0, C_LDUSE, 0, 1);
        tbl[2]  = mk(1, 1, 0, 0, 0, 5'd0, 5'd0, 0, 1, 5'd0, 0, C_NORM,  0, 1);
        tbl[3]  = mk(1, 1, 0, 0, 0, 5'd1, 5'd7, 1, 1, 5'd7, 0, C_LDUSE, 0, 1);
        tbl[4]  = mk(1, 1, 0, 0, 0, 5'd1, 5'd7, 0, 1, 5'd7, 0, C_NORM,  0, 1);
        tbl[5]  = mk(1, 1, 0, 0, 0, 5'd5, 5'd0, 0, 0, 5'd5, 0, C_NORM,  0, 1);
        tbl[6]  = mk(0, 1, 0, 0, 0, 5'd5, 5'd0, 0, 1, 5'd5, 1, C_REDIR, 0, 1);
        tbl[7]  = mk(0, 1, 0, 0, 0, 5'd5, 5'd0, 0, 1, 5'd5, 0, C_LDUSE, 0, 1);
        tbl[8]  = mk(1, 0, 0, 1, 0, 5'd0, 5'd0, 0, 0, 5'd0, 1, C_FROZEN,0, 1);
        tbl[9]  = mk(1, 0, 0, 0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, C_NORM,  0, 1);
        tbl[10] = mk(0, 1, 1, 0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, C_IMISS, 0, 1);
        tbl[11] = mk(1, 1, 1, 1, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, C_NORM,  0, 1);

        do_reset();
        for (int i = 0; i < 12; i++) step(tbl[i], $sformatf("vec%0d", i));

        // dmem wait masks a redirect for 4 cycles, then the redirect is serviced
        do_reset();
        for (int i = 0; i < 4; i++)
            step(mk(1, 0, 1, 0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 1, C_FROZEN, 0, 1), "dwait_redir");
        step(mk(1, 1, 1, 0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 1, C_REDIR, 0, 1), "dwait_release");

        // three ifetch misses, counter ends at 3
        do_reset();
        for (int i = 0; i < 3; i++)
            step(mk(0, 1, 0, 0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, C_IMISS, 0, 1), "imiss");
        step(idle(C_NORM, 0, 1), "imiss_after");

        // halt held off by a dmem wait, then drain and sticky halted
        step(mk(1, 0, 1, 0, 1, 5'd0, 5'd0, 0, 0, 5'd0, 0, C_FROZEN, 0, 1), "halt_dwait");
        step(mk(1, 1, 1, 0, 1, 5'd0, 5'd0, 0, 0, 5'd0, 0, C_NORM, 0, 1), "halt_enter");
        for (int i = 0; i < DRAIN_CYCLES; i++) step(idle(C_DRAIN, 0, 0), "drain");
        for (int i = 0; i < 3; i++)
            step(mk(0, 0, 1, 0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 1, C_HALT, 1, 0), "halted");

        // reset from HALTED clears halted
        do_reset();
        step(idle(C_NORM, 0, 1), "post_halt_run");

        // reset in the middle of DRAIN
        step(mk(1, 1, 0, 0, 1, 5'd0, 5'd0, 0, 0, 5'd0, 0, C_NORM, 0, 1), "halt_enter2");
        step(idle(C_DRAIN, 0, 0), "drain_once");
        do_reset();
        step(idle(C_NORM, 0, 1), "post_drain_reset");

        // stall counter saturation (4-bit)
        for (int i = 0; i < 20; i++)
            step(mk(0, 1, 0, 0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, C_IMISS, 0, 1), "sat");
        step(idle(C_NORM, 0, 1), "sat_final");

        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL sb_leftover: got %0d entries expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
